// File: rtl/gate_truth_checker.sv
// gate_truth_checker: self-checking driver for a 2-input combinational gate.
// Drives {a,b} = 00,01,10,11, holds each vector SETTLE_CYCLES cycles, samples
// dut_o once per vector against a 4-entry truth table latched at start.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a run (accepted only in IDLE)
//   truth_tbl[3:0]      expected output, bit i for {a,b} == i
//   dut_a, dut_b        registered gate inputs
//   dut_o               gate output under test
//   busy, done          run in progress / one-cycle results-valid pulse
//   pass, err_cnt,      run result, saturating mismatch count and per-vector
//   fail_vec[3:0]       fail mask, held until the next accepted start
module gate_truth_checker #(
   parameter int SETTLE_CYCLES = 1,
   parameter int ERR_W         = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       truth_tbl,
   output logic             dut_a,
   output logic             dut_b,
   input  logic             dut_o,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [3:0]       fail_vec
);
   localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0]    CNT_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

   state_t           state, state_n;
   logic [1:0]       idx, idx_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [3:0]       tbl_q, tbl_n, fail_n;
   logic             busy_n, done_n, pass_n;
   logic [ERR_W-1:0] err_n;

   // idx doubles as the applied vector; it wraps to 0 on leaving the last
   // SAMPLE, which returns the gate inputs to 00 in FINISH
   assign dut_a = idx[1];
   assign dut_b = idx[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         cnt      <= '0;
         tbl_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= '0;
         fail_vec <= '0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         cnt      <= cnt_n;
         tbl_q    <= tbl_n;
         busy     <= busy_n;
         done     <= done_n;
         pass     <= pass_n;
         err_cnt  <= err_n;
         fail_vec <= fail_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      tbl_n   = tbl_q;
      busy_n  = busy;
      done_n  = 1'b0;
      pass_n  = pass;
      err_n   = err_cnt;
      fail_n  = fail_vec;
      case (state)
         IDLE: if (start) begin
            state_n = SETTLE;
            tbl_n   = truth_tbl;
            idx_n   = '0;
            cnt_n   = CNT_LOAD;
            busy_n  = 1'b1;
            pass_n  = 1'b0;
            err_n   = '0;
            fail_n  = '0;
         end
         SETTLE: begin
            cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
            state_n = cnt == '0 ? SAMPLE : SETTLE;
         end
         SAMPLE: begin
            if (dut_o != tbl_q[idx]) begin
               fail_n[idx] = 1'b1;
               err_n       = err_cnt == ERR_MAX ? err_cnt : err_cnt + 1'b1;
            end
            idx_n = idx + 1'b1;
            cnt_n = CNT_LOAD;
            if (idx == 2'd3) begin
               state_n = FINISH;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               pass_n  = err_n == '0;
            end else begin
               state_n = SETTLE;
            end
         end
         FINISH: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: directed bench for gate_truth_checker with three
// instances (SETTLE=1/ERR_W=3 with selectable gate, ERR_W=2 on an OR gate,
// SETTLE=4 on a NOR gate).
module tb_gate_truth_checker;
   logic       clk = 1'b0, rst = 1'b1;
   logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
   logic [3:0] tbl = 4'b0001;
   logic [1:0] mode0 = 2'd0;
   logic       a0, b0, o0, busy0, done0, pass0;
   logic       a1, b1, o1, busy1, done1, pass1;
   logic       a2, b2, o2, busy2, done2, pass2;
   logic [2:0] err0, err2;
   logic [1:0] err1;
   logic [3:0] fail0, fail1, fail2;
   int         n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   // mode0: 0 = NOR, 1 = stuck at 0, 2 = OR
   assign o0 = mode0 == 2'd0 ? ~(a0 | b0) : mode0 == 2'd1 ? 1'b0 : (a0 | b0);
   assign o1 = a1 | b1;
   assign o2 = ~(a2 | b2);

   gate_truth_checker #(.SETTLE_CYCLES(1), .ERR_W(3)) u0 (
      .clk(clk), .rst(rst), .start(start0), .truth_tbl(tbl), .dut_a(a0), .dut_b(b0),
      .dut_o(o0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fail0));
   gate_truth_checker #(.SETTLE_CYCLES(1), .ERR_W(2)) u1 (
      .clk(clk), .rst(rst), .start(start1), .truth_tbl(tbl), .dut_a(a1), .dut_b(b1),
      .dut_o(o1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fail1));
   gate_truth_checker #(.SETTLE_CYCLES(4), .ERR_W(3)) u2 (
      .clk(clk), .rst(rst), .start(start2), .truth_tbl(tbl), .dut_a(a2), .dut_b(b2),
      .dut_o(o2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_vec(fail2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset0(input string tag);
      chk({tag, "_vec"}, 32'({a0, b0}), 0);
      chk({tag, "_busy"}, 32'(busy0), 0);
      chk({tag, "_done"}, 32'(done0), 0);
      chk({tag, "_pass"}, 32'(pass0), 0);
      chk({tag, "_err"}, 32'(err0), 0);
      chk({tag, "_fail"}, 32'(fail0), 0);
   endtask

   // called at a negedge with u0 idle; k counts negedges after the accepting edge
   task automatic run0(input logic [1:0] m, input logic mid_tbl, input logic mid_start,
                       input logic [2:0] e_err, input logic [3:0] e_fail, input logic e_pass);
      mode0  = m;
      tbl    = 4'b0001;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int k = 0; k <= 9; k++) begin
         chk("vec", 32'({a0, b0}), k < 8 ? k >> 1 : 0);
         chk("busy", 32'(busy0), 32'(k < 8));
         chk("done", 32'(done0), 32'(k == 8));
         if (k == 0) begin
            chk("clr_err", 32'(err0), 0);
            chk("clr_fail", 32'(fail0), 0);
            chk("clr_pass", 32'(pass0), 0);
         end
         if (k >= 8) begin
            chk("err_cnt", 32'(err0), 32'(e_err));
            chk("fail_vec", 32'(fail0), 32'(e_fail));
            chk("pass", 32'(pass0), 32'(e_pass));
         end
         if (mid_tbl && k == 3) tbl = 4'b1111;
         start0 = mid_start && (k == 2 || k == 5);
         @(negedge clk);
      end
      start0 = 1'b0;
      tbl    = 4'b0001;
   endtask

   initial begin
      int seen, dones, t;
      repeat (2) @(negedge clk);
      chk_reset0("rst");
      rst = 1'b0;
      @(negedge clk);
      run0(2'd0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b1);
      run0(2'd1, 1'b0, 1'b0, 3'd1, 4'b0001, 1'b0);
      run0(2'd2, 1'b0, 1'b0, 3'd4, 4'b1111, 1'b0);
      run0(2'd0, 1'b1, 1'b1, 3'd0, 4'b0000, 1'b1);
      // reset mid-run
      mode0  = 2'd2;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset0("midrst");
      rst  = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         seen |= int'(done0);
      end
      chk("midrst_nodone", 32'(seen), 0);
      run0(2'd0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b1);
      // start held high: runs every 10 cycles
      start0 = 1'b1;
      dones  = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done0) begin
            dones++;
            chk("bb_pass", 32'(pass0), 1);
            chk("bb_k", k, 8 + 10 * (dones - 1));
         end
      end
      start0 = 1'b0;
      chk("bb_dones", dones, 3);
      repeat (3) @(negedge clk);
      // saturating counter, ERR_W=2
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      t = 0;
      while (!done1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("sat_lat", t, 8);
      chk("sat_err", 32'(err1), 3);
      chk("sat_fail", 32'(fail1), 32'hf);
      chk("sat_pass", 32'(pass1), 0);
      // SETTLE_CYCLES=4
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int k = 0; k <= 21; k++) begin
         chk("s4_vec", 32'({a2, b2}), k < 20 ? k / 5 : 0);
         chk("s4_busy", 32'(busy2), 32'(k < 20));
         chk("s4_done", 32'(done2), 32'(k == 20));
         if (k == 20) begin
            chk("s4_pass", 32'(pass2), 1);
            chk("s4_err", 32'(err2), 0);
            chk("s4_fail", 32'(fail2), 0);
         end
         @(negedge clk);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
